scope_capture_ctrl: RTL and testbench
=====================================

Name: scope_capture_ctrl

Overview:
Capture sequencer for the internal logic analyzer sample memory.
- Sequences arm, pre-fill, primed, trigger, holdoff and stopped, then reads the frozen buffer out oldest-first over a valid/ready handshake.
- Drives write enable and address of the external dual-port sample RAM.
- Exports primed/stopped status to the host-side register block.

Parameters:
ADDR_WIDTH, 4, sample RAM address width; DEPTH = 2**ADDR_WIDTH
HOLDOFF_WIDTH, 8, width of i_holdoff and the internal holdoff counter

Ports:
clk  input  1  sample clock
reset  input  1  asynchronous, active-high reset
i_arm  input  1  single-cycle pulse: start (or restart) a capture
i_trigger  input  1  trigger condition, sampled every clk
i_holdoff  input  HOLDOFF_WIDTH  post-trigger samples to keep, latched at trigger
o_wr_en  output  1  sample RAM write enable
o_wr_addr  output  ADDR_WIDTH  sample RAM write address
primed  output  1  buffer filled, trigger armed
stopped  output  1  capture frozen, readout in progress
o_trig_addr  output  ADDR_WIDTH  RAM address written in the trigger cycle
o_rd_valid  output  1  o_rd_addr holds a valid readout address
o_rd_addr  output  ADDR_WIDTH  sample RAM read address
o_rd_last  output  1  final readout beat
i_rd_ready  input  1  consumer accepts current beat

Behaviour:
- Reset values: state IDLE; all outputs 0; internal counters 0. Reset mid-capture aborts immediately with no further writes.
- FSM states: IDLE, FILL, PRIMED, HOLDOFF, STOPPED.
- IDLE:
  - all outputs 0 except o_trig_addr, which holds its last value.
  - i_arm moves to FILL next cycle, with o_wr_addr = 0.
- FILL:
  - o_wr_en = 1 every cycle; o_wr_addr increments by 1 each cycle.
  - After the cycle writing DEPTH-1, go to PRIMED; o_wr_addr wraps to 0.
  - i_trigger is ignored.
- PRIMED:
  - primed = 1; writes continue circularly, wrapping DEPTH-1 -> 0.
  - i_trigger = 1 in a PRIMED cycle:
    - that cycle's write is the trigger sample; o_trig_addr <= o_wr_addr.
    - latch eff_holdoff = min(i_holdoff, DEPTH-1), so the trigger sample is never overwritten.
    - holdoff counter <= 0.
  - If eff_holdoff == 0, go to STOPPED; otherwise go to HOLDOFF.
- HOLDOFF:
  - primed = 1; writes continue; counter increments once per write.
  - The write that brings the counter to eff_holdoff is the last one; go to STOPPED.
  - Total samples after the trigger sample = eff_holdoff.
  - i_trigger is ignored.
- STOPPED:
  - o_wr_en = 0, primed = 0, stopped = 1.
  - Last written address L = o_trig_addr + eff_holdoff, mod DEPTH.
  - Readout starts at L+1 (mod DEPTH) with o_rd_valid = 1 in the first STOPPED cycle.
  - A beat transfers when o_rd_valid && i_rd_ready; o_rd_addr then advances by 1 (mod DEPTH). It is held stable while not ready.
  - Exactly DEPTH beats; o_rd_last = 1 on the beat with o_rd_addr == L.
  - After the last transfer, go to IDLE: stopped and o_rd_valid go 0 next cycle.
- i_arm in any non-IDLE state:
  - aborts and restarts FILL at address 0 next cycle.
  - primed/stopped clear next cycle; o_trig_addr keeps its old value until the next trigger.
- i_arm has priority over i_trigger in the same cycle.
- All arithmetic wraps modulo DEPTH on addresses; the holdoff compare is unsigned at HOLDOFF_WIDTH.

Optional Feature:
AUTO_REARM_EN
- Defined: after the final readout transfer, go directly to FILL (address 0) instead of IDLE, giving continuous triggered captures.
- Defined: the IDLE -> FILL transition on i_arm still works after reset.
- Undefined: return to IDLE and wait for i_arm.

Test Plan:
All scenarios use ADDR_WIDTH=3 (DEPTH=8).
- Basic capture:
  - Stimulus: i_arm at cycle 0, i_holdoff=2, i_trigger pulsed in the PRIMED cycle with o_wr_addr=3.
  - Response: FILL writes 0..7 in cycles 1..8; primed=1 from cycle 9; writes 3,4,5; o_trig_addr=3; stopped=1; readout order 6,7,0,1,2,3,4,5 with o_rd_last on 5; then IDLE.
- Early trigger:
  - Stimulus: i_trigger held high during all of FILL, then low.
  - Response: no trigger, remains PRIMED writing circularly.
- Zero holdoff and clamp:
  - Stimulus (a): i_holdoff=0, trigger at addr 6. Response: o_wr_en=0 next cycle; readout 7,0..6.
  - Stimulus (b): i_holdoff=200. Response: exactly 7 post-trigger writes; readout starts at trig_addr.
- Backpressure:
  - Stimulus: i_rd_ready toggled 1,0,0,1,... during readout.
  - Response: o_rd_addr stable while not ready; exactly 8 transfers, no skips or duplicates.
- Abort and reset:
  - Stimulus (a): i_arm during HOLDOFF. Response: FILL at address 0 next cycle; stopped never asserts.
  - Stimulus (b): reset asserted during STOPPED. Response: all outputs 0 immediately, without waiting for a clock edge.
- AUTO_REARM_EN defined:
  - Stimulus: complete one capture and readout.
  - Response: the cycle after the o_rd_last transfer has o_wr_en=1 with o_wr_addr=0, with no i_arm.

Source files
------------

// File: rtl/scope_capture_ctrl_if.sv
// Bundle of the capture controller's trigger, RAM write, status and readout signals.
// The slave modport is the controller side; the master modport is the host/driver side.
interface scope_capture_ctrl_if #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned HOLDOFF_WIDTH = 8
);
  logic                     i_arm;
  logic                     i_trigger;
  logic [HOLDOFF_WIDTH-1:0] i_holdoff;
  logic                     o_wr_en;
  logic [ADDR_WIDTH-1:0]    o_wr_addr;
  logic                     primed;
  logic                     stopped;
  logic [ADDR_WIDTH-1:0]    o_trig_addr;
  logic                     o_rd_valid;
  logic [ADDR_WIDTH-1:0]    o_rd_addr;
  logic                     o_rd_last;
  logic                     i_rd_ready;

  modport slave (
    input  i_arm, i_trigger, i_holdoff, i_rd_ready,
    output o_wr_en, o_wr_addr, primed, stopped, o_trig_addr, o_rd_valid, o_rd_addr, o_rd_last
  );

  modport master (
    output i_arm, i_trigger, i_holdoff, i_rd_ready,
    input  o_wr_en, o_wr_addr, primed, stopped, o_trig_addr, o_rd_valid, o_rd_addr, o_rd_last
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Capture sequencer for the logic analyzer sample RAM: fill, prime, trigger, holdoff,
// freeze, then read the frozen buffer out oldest-first over valid/ready.
// Optional macro AUTO_REARM_EN: after the final readout beat restart FILL instead of IDLE.
module scope_capture_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned HOLDOFF_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  scope_capture_ctrl_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]    LastAddr = ADDR_WIDTH'(Depth - 1);
  localparam logic [HOLDOFF_WIDTH-1:0] MaxHold  = HOLDOFF_WIDTH'(Depth - 1);

  typedef enum logic [2:0] {StIdle, StFill, StPrimed, StHoldoff, StStopped} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]    trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] eff_hold_q, eff_hold_d;

  logic [HOLDOFF_WIDTH-1:0] clamp_hold;
  logic [ADDR_WIDTH-1:0]    last_addr;
  logic                     writing;
  logic                     rd_xfer;
  logic                     rd_last;

  // Clamp keeps the trigger sample from being overwritten by the holdoff writes.
  assign clamp_hold = (bus.i_holdoff > MaxHold) ? MaxHold : bus.i_holdoff;
  // Write pointer is frozen in STOPPED one past the last written address.
  assign last_addr  = wr_addr_q - ADDR_WIDTH'(1);
  assign writing    = (state_q == StFill) || (state_q == StPrimed) || (state_q == StHoldoff);
  assign rd_last    = (state_q == StStopped) && (rd_addr_q == last_addr);
  assign rd_xfer    = (state_q == StStopped) && bus.i_rd_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arm overrides everything, including a same-cycle trigger.
  always_comb begin
    state_d = state_q;
    if (bus.i_arm) begin
      state_d = StFill;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StFill:    if (wr_addr_q == LastAddr) state_d = StPrimed;
        StPrimed:  if (bus.i_trigger) state_d = (clamp_hold == '0) ? StStopped : StHoldoff;
        StHoldoff: if (hold_cnt_q + HOLDOFF_WIDTH'(1) == eff_hold_q) state_d = StStopped;
        StStopped: begin
          if (rd_xfer && rd_last) begin
`ifdef AUTO_REARM_EN
            state_d = StFill;
`else
            state_d = StIdle;
`endif
          end
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  // Datapath next values: write pointer, trigger capture, holdoff count, read pointer.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    rd_addr_d   = rd_addr_q;
    hold_cnt_d  = hold_cnt_q;
    eff_hold_d  = eff_hold_q;
    if (bus.i_arm) begin
      wr_addr_d  = '0;
      hold_cnt_d = '0;
    end else begin
      if (writing) begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        // Oldest sample after the final write sits just past it.
        rd_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end
      if (state_q == StPrimed && bus.i_trigger) begin
        trig_addr_d = wr_addr_q;
        eff_hold_d  = clamp_hold;
        hold_cnt_d  = '0;
      end
      if (state_q == StHoldoff) begin
        hold_cnt_d = hold_cnt_q + HOLDOFF_WIDTH'(1);
      end
      if (rd_xfer) begin
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        if (rd_last) begin
          wr_addr_d  = '0;
          hold_cnt_d = '0;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      rd_addr_q   <= '0;
      hold_cnt_q  <= '0;
      eff_hold_q  <= '0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      rd_addr_q   <= rd_addr_d;
      hold_cnt_q  <= hold_cnt_d;
      eff_hold_q  <= eff_hold_d;
    end
  end

  // Outputs decoded from state and registers only, so reset clears them at once.
  always_comb begin
    bus.o_wr_en     = writing;
    bus.o_wr_addr   = wr_addr_q;
    bus.primed      = (state_q == StPrimed) || (state_q == StHoldoff);
    bus.stopped     = (state_q == StStopped);
    bus.o_trig_addr = trig_addr_q;
    bus.o_rd_valid  = (state_q == StStopped);
    bus.o_rd_addr   = (state_q == StStopped) ? rd_addr_q : '0;
    bus.o_rd_last   = rd_last;
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl at ADDR_WIDTH=3 (DEPTH=8).
// Honours AUTO_REARM_EN when defined for the build.
module tb_scope_capture_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned HW    = 8;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  scope_capture_ctrl_if #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) bus ();

  scope_capture_ctrl #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full capture: arm, fill, optional early trigger, trigger after d primed cycles,
  // holdoff, readout with the chosen ready pattern. Expected values come from the
  // fact that every write is consecutive mod DEPTH starting at 0.
  task automatic capture(input int unsigned hold, input int unsigned d, input bit early,
                         input int ready_mode, input string tag);
    int unsigned eff, n_wr, trig_a, last_a, j, guard;
    logic [AW-1:0] exp_a;
    bit r;
    eff    = (hold > DEPTH - 1) ? DEPTH - 1 : hold;
    n_wr   = DEPTH + 1 + d + eff;
    trig_a = d % DEPTH;
    last_a = (n_wr - 1) % DEPTH;
    bus.i_arm = 1'b1;
    bus.i_holdoff = HW'($urandom);
    step();
    bus.i_arm = 1'b0;
    for (int unsigned k = 0; k < n_wr; k++) begin
      exp_a = AW'(k % DEPTH);
      n_checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== exp_a || bus.primed !== (k >= DEPTH)
          || bus.stopped !== 1'b0) begin
        $display("FAIL %s write k=%0d: wr_en=%b addr=%0d primed=%b stopped=%b, want 1 %0d %b 0",
                 tag, k, bus.o_wr_en, bus.o_wr_addr, bus.primed, bus.stopped, exp_a,
                 (k >= DEPTH));
      end else n_pass++;
      bus.i_trigger = (k < DEPTH) ? early : (k == DEPTH + d);
      // Holdoff is only meaningful in the trigger cycle; scramble it elsewhere.
      bus.i_holdoff = (k == DEPTH + d) ? HW'(hold) : HW'($urandom);
      step();
    end
    bus.i_trigger = 1'b0;
    j = 0;
    guard = 0;
    while (j < DEPTH && guard < 64) begin
      exp_a = AW'((last_a + 1 + j) % DEPTH);
      n_checks++;
      if (bus.o_wr_en !== 1'b0 || bus.stopped !== 1'b1 || bus.primed !== 1'b0
          || bus.o_rd_valid !== 1'b1 || bus.o_rd_addr !== exp_a
          || bus.o_rd_last !== (j == DEPTH - 1) || bus.o_trig_addr !== AW'(trig_a)) begin
        $display("FAIL %s read j=%0d: wr_en=%b stopped=%b primed=%b valid=%b addr=%0d last=%b trig=%0d, want 0 1 0 1 %0d %b %0d",
                 tag, j, bus.o_wr_en, bus.stopped, bus.primed, bus.o_rd_valid, bus.o_rd_addr,
                 bus.o_rd_last, bus.o_trig_addr, exp_a, (j == DEPTH - 1), trig_a);
      end else n_pass++;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (guard % 3 == 0);
        default: r = 1'($urandom);
      endcase
      bus.i_rd_ready = r;
      step();
      if (r) j++;
      guard++;
    end
    bus.i_rd_ready = 1'b0;
    if (j < DEPTH) begin
      n_checks++;
      $display("FAIL %s readout timeout: beats=%0d, want %0d", tag, j, DEPTH);
    end
    n_checks++;
`ifdef AUTO_REARM_EN
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== '0 || bus.stopped !== 1'b0
        || bus.o_rd_valid !== 1'b0) begin
      $display("FAIL %s rearm: wr_en=%b addr=%0d stopped=%b valid=%b, want 1 0 0 0",
               tag, bus.o_wr_en, bus.o_wr_addr, bus.stopped, bus.o_rd_valid);
    end else n_pass++;
`else
    if (bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== '0 || bus.stopped !== 1'b0
        || bus.o_rd_valid !== 1'b0 || bus.primed !== 1'b0 || bus.o_trig_addr !== AW'(trig_a)) begin
      $display("FAIL %s idle: wr_en=%b addr=%0d stopped=%b valid=%b primed=%b trig=%0d, want 0 0 0 0 0 %0d",
               tag, bus.o_wr_en, bus.o_wr_addr, bus.stopped, bus.o_rd_valid, bus.primed,
               bus.o_trig_addr, trig_a);
    end else n_pass++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_arm = 1'b0;
    bus.i_trigger = 1'b0;
    bus.i_holdoff = '0;
    bus.i_rd_ready = 1'b0;
    #3;
    n_checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.primed, bus.stopped, bus.o_trig_addr, bus.o_rd_valid,
         bus.o_rd_addr, bus.o_rd_last} !== '0) begin
      $display("FAIL reset outputs: wr_en=%b addr=%0d primed=%b stopped=%b trig=%0d valid=%b rd=%0d last=%b, want all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.primed, bus.stopped, bus.o_trig_addr,
               bus.o_rd_valid, bus.o_rd_addr, bus.o_rd_last);
    end else n_pass++;
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.o_wr_en !== 1'b0 || bus.stopped !== 1'b0) begin
      $display("FAIL reset idle hold: wr_en=%b stopped=%b, want 0 0", bus.o_wr_en, bus.stopped);
    end else n_pass++;
  endtask

  task automatic test_basic();
    capture(2, 3, 1'b0, 0, "basic");
  endtask

  task automatic test_early_trigger();
    capture(1, 13, 1'b1, 0, "early_trig");
  endtask

  task automatic test_zero_holdoff_and_clamp();
    capture(0, 6, 1'b0, 0, "zero_hold");
    capture(200, 4, 1'b0, 0, "clamp_hold");
  endtask

  task automatic test_backpressure();
    capture(3, 2, 1'b0, 1, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      capture($urandom_range(0, 255), $urandom_range(0, 20), 1'($urandom), 2, "random");
    end
  endtask

  task automatic test_abort();
    int unsigned d;
    d = 2;
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
    for (int unsigned k = 0; k <= DEPTH + d + 1; k++) begin
      bus.i_trigger = (k == DEPTH + d);
      bus.i_holdoff = 8'd5;
      bus.i_arm = (k == DEPTH + d + 1);
      step();
    end
    bus.i_arm = 1'b0;
    bus.i_trigger = 1'b0;
    n_checks++;
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== '0 || bus.primed !== 1'b0
        || bus.stopped !== 1'b0 || bus.o_trig_addr !== AW'(d)) begin
      $display("FAIL abort restart: wr_en=%b addr=%0d primed=%b stopped=%b trig=%0d, want 1 0 0 0 %0d",
               bus.o_wr_en, bus.o_wr_addr, bus.primed, bus.stopped, bus.o_trig_addr, d);
    end else n_pass++;
    for (int unsigned c = 1; c < 20; c++) begin
      step();
      n_checks++;
      if (bus.stopped !== 1'b0 || bus.o_wr_addr !== AW'(c % DEPTH)) begin
        $display("FAIL abort run c=%0d: stopped=%b addr=%0d, want 0 %0d",
                 c, bus.stopped, bus.o_wr_addr, c % DEPTH);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_in_stopped();
    int guard;
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
    for (int unsigned k = 0; k <= DEPTH; k++) begin
      bus.i_trigger = (k == DEPTH);
      bus.i_holdoff = 8'd1;
      step();
    end
    bus.i_trigger = 1'b0;
    guard = 0;
    while (bus.stopped !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (bus.stopped !== 1'b1) begin
      $display("FAIL reset_stopped reach: stopped=%b, want 1", bus.stopped);
    end else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.primed, bus.stopped, bus.o_trig_addr, bus.o_rd_valid,
         bus.o_rd_addr, bus.o_rd_last} !== '0) begin
      $display("FAIL reset_stopped async: wr_en=%b stopped=%b valid=%b rd=%0d trig=%0d, want all 0",
               bus.o_wr_en, bus.stopped, bus.o_rd_valid, bus.o_rd_addr, bus.o_trig_addr);
    end else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_trigger();
    test_zero_holdoff_and_clamp();
    test_backpressure();
    test_random();
    test_abort();
    test_reset_in_stopped();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
